sha256_sched_ctrl: RTL and testbench

SHA256_SCHED_CTRL -- requirements
Module: sha256_sched_ctrl

---
 rtl/sha256_sched_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sha256_sched_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl: SHA-256 message-schedule and round-sequencing controller.
// Collects 16 message words in IDLE, then streams W[t] and K[t] for rounds
// 0..63 in ROUND (holding on datapath stall), and opens a FINAL window of
// FINAL_CYC cycles for the feed-forward add before returning to IDLE.
// Build option: define SHA_MASKED_STORE_EN to keep buffer entries byte-rotated
// by a random offset (stored alongside the word) and un-rotated on read.
module sha256_sched_ctrl #(
  parameter int FINAL_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_word,
  input  logic        first_block,
  input  logic        mode224,
  input  logic [1:0]  rnd,
  input  logic        dp_stall,
  output logic        iv_load,
  output logic        iv_sel,
  output logic        rnd_valid,
  output logic [31:0] w_t,
  output logic [31:0] k_t,
  output logic [5:0]  t,
  output logic        fin,
  output logic        busy
);

`ifdef SHA_MASKED_STORE_EN
  localparam int BW = 34;
`else
  localparam int BW = 32;
`endif

  localparam logic [1:0] FIN_LAST = 2'(FINAL_CYC - 1);

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] msg_buf [16];
  logic [3:0]    wcnt;
  logic [1:0]    fcnt;
  logic          first_q;
  logic          mode_q;

  logic          hs;
  logic          adv;
  logic [5:0]    t_nxt;
  logic [3:0]    idx_m2;
  logic [3:0]    idx_m7;
  logic [3:0]    idx_m15;
  logic [31:0]   w_sched;
  logic [31:0]   w_nxt;
  logic [31:0]   w_first;
  logic          buf_we;
  logic [3:0]    buf_waddr;
  logic [31:0]   buf_wdata;
  logic [BW-1:0] buf_entry;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef SHA_MASKED_STORE_EN
  function automatic logic [33:0] mask_word(input logic [31:0] w, input logic [1:0] r);
    case (r)
      2'd1:    return {r, w[7:0],  w[31:8]};
      2'd2:    return {r, w[15:0], w[31:16]};
      2'd3:    return {r, w[23:0], w[31:24]};
      default: return {r, w};
    endcase
  endfunction

  function automatic logic [31:0] unmask_word(input logic [33:0] e);
    case (e[33:32])
      2'd1:    return {e[23:0], e[31:24]};
      2'd2:    return {e[15:0], e[31:16]};
      2'd3:    return {e[7:0],  e[31:8]};
      default: return e[31:0];
    endcase
  endfunction

  assign buf_entry = mask_word(buf_wdata, rnd);
`else
  logic unused_rnd;

  function automatic logic [31:0] unmask_word(input logic [31:0] e);
    return e;
  endfunction

  assign buf_entry  = buf_wdata;
  assign unused_rnd = ^rnd;
`endif

  assign msg_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign hs        = msg_valid && msg_ready;
  assign adv       = (state == ROUND) && !dp_stall;
  assign w_first   = unmask_word(msg_buf[4'd0]);

  // Next schedule word: straight from the buffer for rounds below 16, else the sigma recurrence over the 16-deep window
  always_comb begin
    t_nxt   = t + 6'd1;
    idx_m2  = t_nxt[3:0] - 4'd2;
    idx_m7  = t_nxt[3:0] - 4'd7;
    idx_m15 = t_nxt[3:0] - 4'd15;
    w_sched = sigma1(unmask_word(msg_buf[idx_m2])) + unmask_word(msg_buf[idx_m7])
            + sigma0(unmask_word(msg_buf[idx_m15])) + unmask_word(msg_buf[t_nxt[3:0]]);
    w_nxt   = (t_nxt[5:4] == 2'd0) ? unmask_word(msg_buf[t_nxt[3:0]]) : w_sched;
  end

  // Buffer write port: message words during load, computed W words written back over W[t-16] during rounds
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = wcnt;
    buf_wdata = msg_word;
    if (hs) begin
      buf_we    = 1'b1;
      buf_waddr = wcnt;
      buf_wdata = msg_word;
    end else if (adv && (t_nxt[5:4] != 2'd0)) begin
      buf_we    = 1'b1;
      buf_waddr = t_nxt[3:0];
      buf_wdata = w_nxt;
    end
  end

  // Sixteen-entry schedule window; contents after reset are irrelevant
  always_ff @(posedge clk) begin
    if (buf_we) begin
      msg_buf[buf_waddr] <= buf_entry;
    end
  end

  // Controller FSM with registered round outputs and one-cycle iv_load/fin pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      fcnt      <= 2'd0;
      t         <= 6'd0;
      first_q   <= 1'b0;
      mode_q    <= 1'b0;
      rnd_valid <= 1'b0;
      iv_load   <= 1'b0;
      iv_sel    <= 1'b0;
      fin       <= 1'b0;
      w_t       <= 32'd0;
      k_t       <= 32'd0;
    end else begin
      iv_load <= 1'b0;
      fin     <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            wcnt <= wcnt + 4'd1;
            if (wcnt == 4'd0) begin
              first_q <= first_block;
              mode_q  <= mode224;
            end
            if (wcnt == 4'd15) begin
              state     <= ROUND;
              t         <= 6'd0;
              rnd_valid <= 1'b1;
              w_t       <= w_first;
              k_t       <= K_TABLE[0];
              iv_load   <= first_q;
              iv_sel    <= mode_q;
            end
          end
        end
        ROUND: begin
          if (!dp_stall) begin
            if (t == 6'd63) begin
              state     <= FINAL;
              rnd_valid <= 1'b0;
              fin       <= 1'b1;
              fcnt      <= 2'd0;
              t         <= 6'd0;
              w_t       <= 32'd0;
              k_t       <= 32'd0;
            end else begin
              t   <= t_nxt;
              w_t <= w_nxt;
              k_t <= K_TABLE[t_nxt];
            end
          end
        end
        FINAL: begin
          if (fcnt == FIN_LAST) begin
            state <= IDLE;
            wcnt  <= 4'd0;
          end else begin
            fcnt <= fcnt + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb_sha256_sched_ctrl: randomized self-checking bench for sha256_sched_ctrl.
// A reference model expands each 16-word block into W[0..63] with plain array
// arithmetic; the bench then walks the rounds, tracking stalls it injects.
module tb_sha256_sched_ctrl;

  localparam int FINAL_CYC = 3;

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic        clk;
  logic        rst;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] msg_word;
  logic        first_block;
  logic        mode224;
  logic [1:0]  rnd;
  logic        dp_stall;
  logic        iv_load;
  logic        iv_sel;
  logic        rnd_valid;
  logic [31:0] w_t;
  logic [31:0] k_t;
  logic [5:0]  t;
  logic        fin;
  logic        busy;

  logic [31:0] blk   [16];
  logic [31:0] w_ref [64];
  int          n_checks = 0;
  int          n_fail   = 0;

  sha256_sched_ctrl #(.FINAL_CYC(FINAL_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .msg_word    (msg_word),
    .first_block (first_block),
    .mode224     (mode224),
    .rnd         (rnd),
    .dp_stall    (dp_stall),
    .iv_load     (iv_load),
    .iv_sel      (iv_sel),
    .rnd_valid   (rnd_valid),
    .w_t         (w_t),
    .k_t         (k_t),
    .t           (t),
    .fin         (fin),
    .busy        (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fresh masking offset every cycle; only the masked build looks at it
  initial begin
    rnd = 2'd0;
    forever begin
      @(negedge clk);
      rnd = 2'($urandom);
    end
  end

  // Hard time limit so a stuck design cannot hang the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic buildRef();
    logic [31:0] s0;
    logic [31:0] s1;
    for (int i = 0; i < 64; i++) begin
      if (i < 16) begin
        w_ref[i] = blk[i];
      end else begin
        s0 = rotr(w_ref[i-15], 7) ^ rotr(w_ref[i-15], 18) ^ (w_ref[i-15] >> 3);
        s1 = rotr(w_ref[i-2], 17) ^ rotr(w_ref[i-2], 19) ^ (w_ref[i-2] >> 10);
        w_ref[i] = s1 + w_ref[i-7] + s0 + w_ref[i-16];
      end
    end
  endtask

  task automatic setAbc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic setRandom();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  // Offer the 16 words of blk; word 0 goes out immediately, later words may follow idle gaps
  task automatic applyStimulus(input logic first, input logic mode);
    int gaps;
    for (int i = 0; i < 16; i++) begin
      gaps = (i == 0) ? 0 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        msg_valid   = 1'b0;
        msg_word    = $urandom;
        first_block = 1'($urandom);
        mode224     = 1'($urandom);
        @(negedge clk);
      end
      msg_valid   = 1'b1;
      msg_word    = blk[i];
      first_block = (i == 0) ? first : 1'($urandom);
      mode224     = (i == 0) ? mode  : 1'($urandom);
      checkOutput("load_msg_ready", 32'(msg_ready), 32'd1);
      checkOutput("load_busy", 32'(busy), 32'd0);
      checkOutput("load_rnd_valid", 32'(rnd_valid), 32'd0);
      @(negedge clk);
    end
    msg_valid = 1'b0;
  endtask

  // Walk the rounds from the first ROUND cycle through FINAL back to IDLE, or abort with rst at round rst_at
  task automatic watchRounds(input logic exp_iv, input logic exp_sel, input int stall_at, input int stall_len,
                             input bit rand_stall, input int rst_at, input bit abc, input bit hold_valid);
    int  et     = 0;
    int  cyc    = 1;
    int  stalls = 0;
    int  forced = 0;
    bit  first  = 1'b1;
    bit  done   = 1'b0;
    bit  seen   = 1'b0;
    while (!done && cyc < 400) begin
      checkOutput("rnd_valid", 32'(rnd_valid), 32'd1);
      checkOutput("t", 32'(t), 32'(et));
      checkOutput("w_t", w_t, w_ref[et]);
      checkOutput("k_t", k_t, K_REF[et]);
      checkOutput("round_msg_ready", 32'(msg_ready), 32'd0);
      checkOutput("round_busy", 32'(busy), 32'd1);
      checkOutput("iv_load", 32'(iv_load), first ? 32'(exp_iv) : 32'd0);
      if (first && exp_iv) checkOutput("iv_sel", 32'(iv_sel), 32'(exp_sel));
      if (abc && et == 0)  checkOutput("abc_w0", w_t, 32'h61626380);
      if (abc && et == 0)  checkOutput("abc_k0", k_t, 32'h428a2f98);
      if (abc && et == 16) checkOutput("abc_w16", w_t, 32'h61626380);
      if (abc && et == 17) checkOutput("abc_w17", w_t, 32'h000F0000);
      if (abc && et == 63) checkOutput("abc_k63", k_t, 32'hc67178f2);
      first = 1'b0;
      if (et == rst_at) begin
        rst       = 1'b1;
        msg_valid = 1'b0;
        dp_stall  = 1'b0;
        @(negedge clk);
        checkOutput("abort_rnd_valid", 32'(rnd_valid), 32'd0);
        checkOutput("abort_iv_load", 32'(iv_load), 32'd0);
        checkOutput("abort_iv_sel", 32'(iv_sel), 32'd0);
        checkOutput("abort_fin", 32'(fin), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_w_t", w_t, 32'd0);
        checkOutput("abort_k_t", k_t, 32'd0);
        checkOutput("abort_t", 32'(t), 32'd0);
        checkOutput("abort_msg_ready", 32'(msg_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("abort_ready_after", 32'(msg_ready), 32'd1);
        repeat (80) begin
          @(negedge clk);
          seen = seen | fin;
        end
        checkOutput("abort_no_fin", 32'(seen), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        return;
      end
      dp_stall = 1'b0;
      if (et == stall_at && forced < stall_len) begin
        dp_stall = 1'b1;
        forced++;
      end else if (rand_stall && $urandom_range(0, 5) == 0) begin
        dp_stall = 1'b1;
      end
      if (dp_stall) stalls++;
      msg_valid = hold_valid;
      msg_word  = $urandom;
      if (!dp_stall) begin
        if (et == 63) done = 1'b1;
        else et++;
      end
      @(negedge clk);
      cyc++;
    end
    dp_stall = 1'b0;
    if (!done) checkOutput("round_timeout", 32'(cyc), 32'(65 + stalls));
    checkOutput("fin", 32'(fin), 32'd1);
    checkOutput("fin_latency", 32'(cyc), 32'(65 + stalls));
    checkOutput("final_rnd_valid", 32'(rnd_valid), 32'd0);
    checkOutput("final_busy", 32'(busy), 32'd1);
    checkOutput("final_msg_ready", 32'(msg_ready), 32'd0);
    for (int i = 1; i <= FINAL_CYC; i++) begin
      msg_valid = hold_valid && (i < FINAL_CYC);
      msg_word  = $urandom;
      @(negedge clk);
      checkOutput("fin_pulse", 32'(fin), 32'd0);
      checkOutput("final_hold_busy", 32'(busy), (i < FINAL_CYC) ? 32'd1 : 32'd0);
    end
    checkOutput("idle_msg_ready", 32'(msg_ready), 32'd1);
  endtask

  // Scenario sequence
  initial begin
    logic f;
    logic m;
    logic h;
    rst         = 1'b1;
    msg_valid   = 1'b0;
    msg_word    = 32'd0;
    first_block = 1'b0;
    mode224     = 1'b0;
    dp_stall    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_msg_ready", 32'(msg_ready), 32'd0);
    checkOutput("rst_rnd_valid", 32'(rnd_valid), 32'd0);
    checkOutput("rst_iv_load", 32'(iv_load), 32'd0);
    checkOutput("rst_iv_sel", 32'(iv_sel), 32'd0);
    checkOutput("rst_fin", 32'(fin), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_w_t", w_t, 32'd0);
    checkOutput("rst_k_t", k_t, 32'd0);
    checkOutput("rst_t", 32'(t), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rst_ready_after", 32'(msg_ready), 32'd1);
    @(negedge clk);

    $display("[TB] abc block, first_block=1");
    setAbc(); buildRef();
    applyStimulus(1'b1, 1'b0);
    watchRounds(1'b1, 1'b0, -1, 0, 1'b0, -1, 1'b1, 1'b0);

    $display("[TB] back-to-back random block, stall of 3 at t=20");
    setRandom(); buildRef();
    applyStimulus(1'b1, 1'b1);
    watchRounds(1'b1, 1'b1, 20, 3, 1'b0, -1, 1'b0, 1'b0);

    $display("[TB] random block aborted by rst at t=30");
    setRandom(); buildRef();
    applyStimulus(1'b1, 1'b0);
    watchRounds(1'b1, 1'b0, -1, 0, 1'b0, 30, 1'b0, 1'b0);

    $display("[TB] abc block after abort");
    setAbc(); buildRef();
    applyStimulus(1'b1, 1'b0);
    watchRounds(1'b1, 1'b0, -1, 0, 1'b0, -1, 1'b1, 1'b0);

    $display("[TB] continuation block, first_block=0 mode224=1, msg_valid held");
    setRandom(); buildRef();
    applyStimulus(1'b0, 1'b1);
    watchRounds(1'b0, 1'b1, -1, 0, 1'b1, -1, 1'b0, 1'b1);

    for (int b = 0; b < 4; b++) begin
      f = 1'($urandom);
      m = 1'($urandom);
      h = 1'($urandom);
      $display("[TB] random block %0d first=%0d mode224=%0d hold=%0d", b, f, m, h);
      setRandom(); buildRef();
      applyStimulus(f, m);
      watchRounds(f, m, -1, 0, 1'b1, -1, 1'b0, h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
